// File: rtl/id_exe_stage.sv
// id_exe_stage: ID->EXE pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubble counter
module id_exe_stage #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int ALU_W  = 4,
  parameter int COL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_op_a,
  input  logic [LANES*DATA_W-1:0] in_op_b,
  input  logic [DATA_W-1:0]       in_sc_a,
  input  logic [DATA_W-1:0]       in_sc_b,
  input  logic [RD_W-1:0]         in_rd,
  input  logic [ALU_W-1:0]        in_alu_ctrl,
  input  logic [COL_W-1:0]        in_col,
  input  logic [6:0]              in_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_op_a,
  output logic [LANES*DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0]       out_sc_a,
  output logic [DATA_W-1:0]       out_sc_b,
  output logic [RD_W-1:0]         out_rd,
  output logic [ALU_W-1:0]        out_alu_ctrl,
  output logic [COL_W-1:0]        out_col,
  output logic [6:0]              out_flags,
  output logic [CNT_W-1:0]        bubble_count
);
  localparam int PW = 2*LANES*DATA_W + 2*DATA_W + RD_W + ALU_W + COL_W + 7;
  logic [PW-1:0] in_pl, main_pl, skid_pl;
  logic          main_valid, skid_valid, acc;
  logic [6:0]    held_flags;
  assign in_pl = {in_op_a, in_op_b, in_sc_a, in_sc_b, in_rd, in_alu_ctrl, in_col, in_flags};
  assign {out_op_a, out_op_b, out_sc_a, out_sc_b, out_rd, out_alu_ctrl, out_col, held_flags} = main_pl;
  // in_ready comes straight from the skid register, so out_ready never reaches it combinationally
  assign in_ready  = !skid_valid;
  assign acc       = in_valid & in_ready;
  assign out_valid = main_valid;
  assign out_flags = held_flags & {7{main_valid}};
  // main slot: refill from skid first to preserve order, otherwise from the input
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_pl    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      main_valid <= skid_valid | acc;
      main_pl    <= skid_valid ? skid_pl : acc ? in_pl : main_pl;
    end
  end
  // skid slot: absorbs the one instruction accepted while main is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_pl    <= '0;
    end else if (flush || (skid_valid && out_ready)) begin
      skid_valid <= 1'b0;
    end else if (acc && main_valid && !out_ready) begin
      skid_valid <= 1'b1;
      skid_pl    <= in_pl;
    end
  end
  // saturating count of cycles where execute was ready but no instruction was offered
  always_ff @(posedge clk) begin
    if (reset) bubble_count <= '0;
    else if (out_ready && !main_valid && !(&bubble_count)) bubble_count <= bubble_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: randomized and directed checks of id_exe_stage against a queue-based reference model
module tb_id_exe_stage;
  localparam int LANES = 4, DATA_W = 32, RD_W = 4, ALU_W = 4, COL_W = 2, CNT_W = 4;
  localparam int PW = 2*LANES*DATA_W + 2*DATA_W + RD_W + ALU_W + COL_W + 7;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0, in_ready, out_valid;
  logic [LANES*DATA_W-1:0] in_op_a = '0, in_op_b = '0, out_op_a, out_op_b;
  logic [DATA_W-1:0] in_sc_a = '0, in_sc_b = '0, out_sc_a, out_sc_b;
  logic [RD_W-1:0] in_rd = '0, out_rd;
  logic [ALU_W-1:0] in_alu_ctrl = '0, out_alu_ctrl;
  logic [COL_W-1:0] in_col = '0, out_col;
  logic [6:0] in_flags = '0, out_flags;
  logic [CNT_W-1:0] bubble_count;
  logic [PW-1:0] in_pl, out_pl;
  logic [PW-1:0] q[$];
  int log_rd[$];
  int cnt = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  id_exe_stage #(.LANES(LANES), .DATA_W(DATA_W), .RD_W(RD_W), .ALU_W(ALU_W), .COL_W(COL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_sc_a(in_sc_a), .in_sc_b(in_sc_b), .in_rd(in_rd),
    .in_alu_ctrl(in_alu_ctrl), .in_col(in_col), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_sc_a(out_sc_a), .out_sc_b(out_sc_b), .out_rd(out_rd), .out_alu_ctrl(out_alu_ctrl),
    .out_col(out_col), .out_flags(out_flags), .bubble_count(bubble_count));
  assign in_pl  = {in_op_a, in_op_b, in_sc_a, in_sc_b, in_rd, in_alu_ctrl, in_col, in_flags};
  assign out_pl = {out_op_a, out_op_b, out_sc_a, out_sc_b, out_rd, out_alu_ctrl, out_col, out_flags};
  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rnd(input int rd);
    for (int i = 0; i < LANES; i++) begin
      in_op_a[i*DATA_W +: DATA_W] = $urandom;
      in_op_b[i*DATA_W +: DATA_W] = $urandom;
    end
    in_sc_a = $urandom;
    in_sc_b = $urandom;
    in_rd = RD_W'(rd);
    in_alu_ctrl = ALU_W'($urandom);
    in_col = COL_W'($urandom);
    in_flags = 7'($urandom);
  endtask
  task automatic tick();
    int n;
    bit a, c;
    n = q.size();
    a = in_valid && n < 2;
    c = out_ready && n > 0;
    @(posedge clk);
    if (reset) begin
      q.delete();
      cnt = 0;
    end else begin
      if (out_ready && n == 0 && cnt < CMAX) cnt++;
      if (out_valid && out_ready) log_rd.push_back(int'(out_rd));
      if (flush) q.delete();
      else begin
        if (c) void'(q.pop_front());
        if (a) q.push_back(in_pl);
      end
    end
    @(negedge clk);
    chk("out_valid", PW'(out_valid), PW'(q.size() > 0));
    chk("in_ready", PW'(in_ready), PW'(q.size() < 2));
    chk("bubble_count", PW'(bubble_count), PW'(cnt));
    if (q.size() > 0) chk("payload", out_pl, q[0]);
    else chk("bubble_flags", PW'(out_flags), '0);
  endtask
  initial begin
    int rd;
    bit a;
    rnd(3);
    in_valid = 1;
    tick();
    tick();
    chk("rst_payload", out_pl, '0);
    reset = 0;
    in_valid = 0;
    tick();
    out_ready = 1;
    log_rd.delete();
    for (int r = 1; r <= 8; r++) begin
      rnd(r);
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    tick();
    tick();
    chk("stream_len", PW'(log_rd.size()), PW'(8));
    foreach (log_rd[i]) chk("stream_order", PW'(log_rd[i]), PW'(i + 1));
    log_rd.delete();
    rd = 1;
    for (int c = 0; c < 20 && rd <= 4; c++) begin
      rnd(rd);
      in_valid = 1;
      out_ready = !(c >= 1 && c <= 3);
      a = q.size() < 2;
      if (c == 2) chk("bp_in_ready_low", PW'(in_ready), '0);
      tick();
      if (a) rd++;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (3) tick();
    chk("bp_all_sent", PW'(rd), PW'(5));
    chk("bp_len", PW'(log_rd.size()), PW'(4));
    foreach (log_rd[i]) chk("bp_order", PW'(log_rd[i]), PW'(i + 1));
    log_rd.delete();
    out_ready = 0;
    rnd(5);
    in_valid = 1;
    tick();
    rnd(6);
    tick();
    chk("fl_skid_full", PW'(in_ready), '0);
    rnd(7);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("fl_valid", PW'(out_valid), '0);
    chk("fl_ready", PW'(in_ready), PW'(1));
    chk("fl_flags", PW'(out_flags), '0);
    out_ready = 1;
    repeat (3) tick();
    rnd(9);
    in_valid = 1;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    repeat (2) tick();
    chk("fl_none_out", PW'(log_rd.size()), '0);
    rnd(10);
    in_flags = 7'h7F;
    in_valid = 1;
    tick();
    rnd(11);
    in_flags = 7'h7F;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("gate_flags", PW'(out_flags), '0);
    tick();
    for (int c = 0; c < 400; c++) begin
      rnd(int'($urandom_range(0, 15)));
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 20) == 0;
      tick();
    end
    flush = 0;
    reset = 1;
    tick();
    reset = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (20) tick();
    chk("sat", PW'(bubble_count), PW'(CMAX));
    flush = 1;
    tick();
    flush = 0;
    chk("sat_flush", PW'(bubble_count), PW'(CMAX));
    out_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("cnt_reset", PW'(bubble_count), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
